// File: rtl/axi_lite_master_q.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_master_q
// Brief    : Queued AXI4-Lite master; commands buffered in a FIFO, one
//            outstanding AXI transaction at a time, response per command.
// Revision : 1.0
// ============================================================================
module axi_lite_master_q #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                  i_aclk,
  input  logic                  i_areset_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_W-1:0]     i_cmd_addr,
  input  logic [DATA_W-1:0]     i_cmd_wdata,
  input  logic [DATA_W/8-1:0]   i_cmd_wstrb,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic                  o_rsp_write,
  output logic [DATA_W-1:0]     o_rsp_rdata,
  output logic [1:0]            o_rsp_resp,
  output logic [ADDR_W-1:0]     o_awaddr,
  output logic                  o_awvalid,
  input  logic                  i_awready,
  output logic [DATA_W-1:0]     o_wdata,
  output logic [DATA_W/8-1:0]   o_wstrb,
  output logic                  o_wvalid,
  input  logic                  i_wready,
  input  logic [1:0]            i_bresp,
  input  logic                  i_bvalid,
  output logic                  o_bready,
  output logic [ADDR_W-1:0]     o_araddr,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  input  logic [DATA_W-1:0]     i_rdata,
  input  logic [1:0]            i_rresp,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  output logic                  o_busy,
  output logic [7:0]            o_err_cnt
);

  localparam int                c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0]  c_depth = (c_ptr_w+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_WR_B = 3'd2,
    S_RD_A = 3'd3,
    S_RD_R = 3'd4,
    S_RSP  = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_fifo_wr    [DEPTH];
  logic [ADDR_W-1:0]     r_fifo_addr  [DEPTH];
  logic [DATA_W-1:0]     r_fifo_wdata [DEPTH];
  logic [DATA_W/8-1:0]   r_fifo_wstrb [DEPTH];
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_ptr_w:0]      r_count;
  logic                  r_rst_done;

  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_wstrb;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic                  r_rsp_write;
  logic [DATA_W-1:0]     r_rsp_rdata;
  logic [1:0]            r_rsp_resp;
  logic [7:0]            r_err_cnt;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_aw_fin;
  logic                  w_w_fin;

  assign w_full      = (r_count == c_depth);
  assign w_empty     = (r_count == '0);
  assign o_cmd_ready = r_rst_done && !w_full;
  assign w_push      = i_cmd_valid && o_cmd_ready;

  assign o_awvalid   = (r_state == S_WR) && !r_aw_done;
  assign o_wvalid    = (r_state == S_WR) && !r_w_done;
  assign o_bready    = (r_state == S_WR_B);
  assign o_arvalid   = (r_state == S_RD_A);
  assign o_rready    = (r_state == S_RD_R);
  assign o_rsp_valid = (r_state == S_RSP);
  assign w_aw_fin    = r_aw_done || (o_awvalid && i_awready);
  assign w_w_fin     = r_w_done  || (o_wvalid  && i_wready);

  assign o_awaddr    = r_addr;
  assign o_araddr    = r_addr;
  assign o_wdata     = r_wdata;
  assign o_wstrb     = r_wstrb;
  assign o_rsp_write = r_rsp_write;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_resp  = r_rsp_resp;
  assign o_err_cnt   = r_err_cnt;
  assign o_busy      = !w_empty || (r_state != S_IDLE);

  // Storage needs no reset; only pointers/count define occupancy.
  always_ff @(posedge i_aclk) begin
    if (w_push) begin
      r_fifo_wr[r_wr_ptr]    <= i_cmd_write;
      r_fifo_addr[r_wr_ptr]  <= i_cmd_addr;
      r_fifo_wdata[r_wr_ptr] <= i_cmd_wdata;
      r_fifo_wstrb[r_wr_ptr] <= i_cmd_wstrb;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = r_fifo_wr[r_rd_ptr] ? S_WR : S_RD_A;
        end
      end
      S_WR:    if (w_aw_fin && w_w_fin) w_state_nxt = S_WR_B;
      S_WR_B:  if (i_bvalid)            w_state_nxt = S_RSP;
      S_RD_A:  if (i_arready)           w_state_nxt = S_RD_R;
      S_RD_R:  if (i_rvalid)            w_state_nxt = S_RSP;
      S_RSP:   if (i_rsp_ready)         w_state_nxt = S_IDLE;
      default:                          w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rst_done  <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
      r_err_cnt   <= 8'd0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_ptr_w+1)'(1);
        2'b01:   r_count <= r_count - (c_ptr_w+1)'(1);
        default: r_count <= r_count;
      endcase

      if (w_pop) begin
        r_addr      <= r_fifo_addr[r_rd_ptr];
        r_wdata     <= r_fifo_wdata[r_rd_ptr];
        r_wstrb     <= r_fifo_wstrb[r_rd_ptr];
        r_rsp_write <= r_fifo_wr[r_rd_ptr];
        r_aw_done   <= 1'b0;
        r_w_done    <= 1'b0;
      end

      if (o_awvalid && i_awready) r_aw_done <= 1'b1;
      if (o_wvalid  && i_wready)  r_w_done  <= 1'b1;

      if (o_bready && i_bvalid) begin
        r_rsp_resp  <= i_bresp;
        r_rsp_rdata <= '0;
      end
      if (o_rready && i_rvalid) begin
        r_rsp_resp  <= i_rresp;
        r_rsp_rdata <= i_rdata;
      end

      // Error count saturates rather than wrapping.
      if (o_rsp_valid && i_rsp_ready && (r_rsp_resp != 2'b00) && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master_q.sv
`default_nettype none
// Bench for axi_lite_master_q: directed commands, AXI-Lite slave model with
// programmable ready skew, and a scoreboard-driven response monitor.
module tb_axi_lite_master_q;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DP = 4;

  logic          aclk = 1'b0;
  logic          areset_n;
  logic          i_cmd_valid, o_cmd_ready, i_cmd_write;
  logic [AW-1:0] i_cmd_addr;
  logic [DW-1:0] i_cmd_wdata;
  logic [3:0]    i_cmd_wstrb;
  logic          o_rsp_valid, i_rsp_ready, o_rsp_write;
  logic [DW-1:0] o_rsp_rdata;
  logic [1:0]    o_rsp_resp;
  logic [AW-1:0] o_awaddr, o_araddr;
  logic          o_awvalid, i_awready, o_wvalid, i_wready;
  logic [DW-1:0] o_wdata, i_rdata;
  logic [3:0]    o_wstrb;
  logic [1:0]    i_bresp, i_rresp;
  logic          i_bvalid, o_bready, o_arvalid, i_arready, i_rvalid, o_rready;
  logic          o_busy;
  logic [7:0]    o_err_cnt;

  axi_lite_master_q #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DP)) dut (
    .i_aclk(aclk), .i_areset_n(areset_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_write(o_rsp_write),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_resp(o_rsp_resp),
    .o_awaddr(o_awaddr), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
    .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
    .o_araddr(o_araddr), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
    .o_busy(o_busy), .o_err_cnt(o_err_cnt)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    bit          wr;
    logic [31:0] rd;
    logic [1:0]  resp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_aw[$];
  logic [35:0] exp_w[$];
  logic [31:0] mem [logic [31:0]];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int lat_meas = 0;
  int rsp_count = 0;
  int aw_count = 0;
  int b_count = 0;
  int aw_delay = 0;
  int w_delay = 0;
  int ar_delay = 0;
  bit b_hold = 1'b0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // AXI-Lite slave: inputs change only on the falling edge, so every
  // handshake decided here completes on the following rising edge.
  initial begin : slave
    int aw_cnt, w_cnt, ar_cnt;
    bit aw_wait, w_wait, ar_wait, aw_got, w_got, b_hs, r_pend, r_hs;
    logic [31:0] aw_h, ar_h, s_awaddr, s_araddr;
    logic [35:0] w_h, s_w;
    logic [31:0] cur;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    {aw_wait, w_wait, ar_wait, aw_got, w_got, b_hs, r_pend, r_hs} = '0;
    i_awready = 0; i_wready = 0; i_arready = 0; i_bvalid = 0; i_rvalid = 0;
    i_bresp = 0; i_rresp = 0; i_rdata = 0;
    forever begin
      @(negedge aclk);
      if (!areset_n) begin
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        {aw_wait, w_wait, ar_wait, aw_got, w_got, b_hs, r_pend, r_hs} = '0;
        i_awready = 0; i_wready = 0; i_arready = 0; i_bvalid = 0; i_rvalid = 0;
        continue;
      end
      if (b_hs) begin i_bvalid = 0; b_hs = 0; end
      if (aw_got && w_got && !b_hold && !i_bvalid) begin
        if (s_awaddr[31:28] == 4'hE) i_bresp = 2'b10;
        else begin
          i_bresp = 2'b00;
          cur = mem.exists(s_awaddr) ? mem[s_awaddr] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (s_w[32+b]) cur[8*b +: 8] = s_w[8*b +: 8];
          mem[s_awaddr] = cur;
        end
        i_bvalid = 1; aw_got = 0; w_got = 0;
      end
      if (i_bvalid && o_bready) begin b_hs = 1; b_count++; end

      if (r_hs) begin i_rvalid = 0; r_hs = 0; end
      if (r_pend) begin
        if (s_araddr[31:28] == 4'hE) begin i_rresp = 2'b10; i_rdata = 32'hBADBAD00; end
        else begin
          i_rresp = 2'b00;
          i_rdata = mem.exists(s_araddr) ? mem[s_araddr] : 32'h0;
        end
        i_rvalid = 1; r_pend = 0;
      end
      if (i_rvalid && o_rready) r_hs = 1;

      if (o_awvalid) begin
        if (aw_wait) chk("awaddr_stable", o_awaddr, aw_h);
        if (aw_cnt >= aw_delay) begin
          i_awready = 1; aw_wait = 0; aw_cnt = 0; aw_got = 1; aw_count++;
          s_awaddr = o_awaddr;
          chk("aw_expected", exp_aw.size() != 0, 1);
          if (exp_aw.size() != 0) chk("awaddr", o_awaddr, exp_aw.pop_front());
        end else begin
          i_awready = 0; aw_wait = 1; aw_h = o_awaddr; aw_cnt++;
        end
      end else begin
        if (aw_wait) chk("awvalid_held", o_awvalid, 1);
        aw_wait = 0; i_awready = 0;
      end

      if (o_wvalid) begin
        if (w_wait) chk("wpayload_stable", {o_wstrb, o_wdata}, w_h);
        if (w_cnt >= w_delay) begin
          i_wready = 1; w_wait = 0; w_cnt = 0; w_got = 1;
          s_w = {o_wstrb, o_wdata};
          chk("w_expected", exp_w.size() != 0, 1);
          if (exp_w.size() != 0) chk("wpayload", {o_wstrb, o_wdata}, exp_w.pop_front());
        end else begin
          i_wready = 0; w_wait = 1; w_h = {o_wstrb, o_wdata}; w_cnt++;
        end
      end else begin
        if (w_wait) chk("wvalid_held", o_wvalid, 1);
        w_wait = 0; i_wready = 0;
      end

      if (o_arvalid) begin
        if (ar_wait) chk("araddr_stable", o_araddr, ar_h);
        if (ar_cnt >= ar_delay) begin
          i_arready = 1; ar_wait = 0; ar_cnt = 0; r_pend = 1; s_araddr = o_araddr;
        end else begin
          i_arready = 0; ar_wait = 1; ar_h = o_araddr; ar_cnt++;
        end
      end else begin
        ar_wait = 0; i_arready = 0;
      end
    end
  end

  // Response monitor: pops the scoreboard on every rsp handshake.
  initial begin : monitor
    bit          prev_v, hold_v;
    logic [34:0] hold_vec;
    exp_t        e;
    prev_v = 0; hold_v = 0; hold_vec = '0;
    forever begin
      @(negedge aclk);
      if (!areset_n) begin prev_v = 0; hold_v = 0; continue; end
      if (o_rsp_valid) begin
        if (hold_v) chk("rsp_stable", {o_rsp_write, o_rsp_rdata, o_rsp_resp}, hold_vec);
        if (!prev_v) lat_meas = cyc - accept_cyc;
        if (i_rsp_ready) begin
          chk("rsp_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_write", o_rsp_write, e.wr);
            chk("rsp_rdata", o_rsp_rdata, e.rd);
            chk("rsp_resp", o_rsp_resp, e.resp);
          end
          rsp_count++;
          hold_v = 0;
        end else begin
          hold_v = 1;
          hold_vec = {o_rsp_write, o_rsp_rdata, o_rsp_resp};
        end
      end else hold_v = 0;
      prev_v = o_rsp_valid;
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [31:0] erd, input logic [1:0] eresp);
    exp_t e;
    bit   ok = 0;
    i_cmd_valid = 1; i_cmd_write = wr; i_cmd_addr = addr;
    i_cmd_wdata = wr ? data : 32'h0; i_cmd_wstrb = wr ? strb : 4'h0;
    for (int n = 0; n < 200; n++) begin
      @(negedge aclk);
      if (o_cmd_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("cmd_accept_timeout", ok, 1);
      i_cmd_valid = 0;
      return;
    end
    accept_cyc = cyc;
    e.wr = wr; e.rd = wr ? 32'h0 : erd; e.resp = eresp;
    sb.push_back(e);
    if (wr) begin exp_aw.push_back(addr); exp_w.push_back({strb, data}); end
    @(posedge aclk); #1;
    i_cmd_valid = 0;
  endtask

  task automatic wait_idle(input int bound);
    bit ok = 0;
    for (int n = 0; n < bound; n++) begin
      @(negedge aclk);
      if (sb.size() == 0 && !o_busy) begin ok = 1; break; end
    end
    chk("idle_reached", ok, 1);
    @(posedge aclk); #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int b0, a0, r0;
    areset_n = 0; i_cmd_valid = 0; i_cmd_write = 0; i_cmd_addr = 0;
    i_cmd_wdata = 0; i_cmd_wstrb = 0; i_rsp_ready = 1;

    repeat (3) @(posedge aclk);
    #1;
    chk("rst_cmd_ready", o_cmd_ready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_valids", {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_rsp_valid}, 0);
    chk("rst_err_cnt", o_err_cnt, 0);
    chk("rst_data", {o_awaddr, o_wdata, o_rsp_rdata}, 0);
    #2 areset_n = 1;
    #1 chk("cmd_ready_before_edge", o_cmd_ready, 0);
    @(posedge aclk); #1;
    chk("cmd_ready_after_release", o_cmd_ready, 1);

    // Single write and read-back, zero-wait slave.
    issue(1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00);
    wait_idle(100);
    chk("lat_write", lat_meas, 4);
    chk("err_cnt_write", o_err_cnt, 0);
    chk("aw_count_single", aw_count, 1);
    chk("b_count_single", b_count, 1);
    issue(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00);
    wait_idle(100);
    chk("lat_read", lat_meas, 4);

    // Partial strobes: only bytes 0 and 2 land.
    issue(1, 32'h20, 32'h11223344, 4'h5, 32'h0, 2'b00);
    issue(0, 32'h20, 32'h0, 4'h0, 32'h00220044, 2'b00);
    wait_idle(100);

    // Fill the FIFO while the first response is stalled.
    i_rsp_ready = 0;
    r0 = rsp_count;
    issue(1, 32'h100, 32'hA5A5A5A5, 4'hF, 32'h0, 2'b00);
    issue(0, 32'h10,  32'h0, 4'h0, 32'hDEADBEEF, 2'b00);
    issue(1, 32'h104, 32'h12345678, 4'hF, 32'h0, 2'b00);
    issue(0, 32'h100, 32'h0, 4'h0, 32'hA5A5A5A5, 2'b00);
    issue(0, 32'h104, 32'h0, 4'h0, 32'h12345678, 2'b00);
    repeat (8) @(posedge aclk);
    #1;
    chk("fifo_full_cmd_ready", o_cmd_ready, 0);
    chk("fifo_full_busy", o_busy, 1);
    chk("fifo_full_no_rsp", rsp_count - r0, 0);
    i_rsp_ready = 1;
    wait_idle(300);
    chk("fifo_drain_count", rsp_count - r0, 5);

    // AW/W skew in both directions.
    b0 = b_count; a0 = aw_count;
    aw_delay = 3; w_delay = 0;
    issue(1, 32'h30, 32'hCAFEF00D, 4'hF, 32'h0, 2'b00);
    wait_idle(100);
    aw_delay = 0; w_delay = 3;
    issue(1, 32'h34, 32'h0BADF00D, 4'hF, 32'h0, 2'b00);
    wait_idle(100);
    w_delay = 0; ar_delay = 2;
    chk("skew_b_count", b_count - b0, 2);
    chk("skew_aw_count", aw_count - a0, 2);
    issue(0, 32'h30, 32'h0, 4'h0, 32'hCAFEF00D, 2'b00);
    issue(0, 32'h34, 32'h0, 4'h0, 32'h0BADF00D, 2'b00);
    wait_idle(100);
    ar_delay = 0;

    // Error path: SLVERR reads until the counter saturates.
    for (int i = 0; i < 254; i++)
      issue(0, 32'hE0000000 + 32'(i * 4), 32'h0, 4'h0, 32'hBADBAD00, 2'b10);
    wait_idle(5000);
    chk("err_cnt_254", o_err_cnt, 254);
    for (int i = 254; i < 300; i++)
      issue(0, 32'hE0000000 + 32'(i * 4), 32'h0, 4'h0, 32'hBADBAD00, 2'b10);
    wait_idle(2000);
    chk("err_cnt_sat", o_err_cnt, 255);
    issue(1, 32'hE0000004, 32'h55AA55AA, 4'hF, 32'h0, 2'b10);
    wait_idle(100);
    chk("err_cnt_sat_write", o_err_cnt, 255);

    // Reset while waiting for B.
    b_hold = 1;
    issue(1, 32'h40, 32'h01020304, 4'hF, 32'h0, 2'b00);
    begin
      bit reached = 0;
      for (int n = 0; n < 50; n++) begin
        @(negedge aclk);
        if (o_bready) begin reached = 1; break; end
      end
      chk("reach_wr_b", reached, 1);
    end
    @(posedge aclk); #1;
    areset_n = 0;
    #1;
    chk("midrst_valids", {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_rsp_valid}, 0);
    chk("midrst_cmd_ready", o_cmd_ready, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_err_cnt", o_err_cnt, 0);
    sb.delete();
    b_hold = 0;
    r0 = rsp_count;
    repeat (2) @(posedge aclk);
    #1 areset_n = 1;
    @(posedge aclk); #1;
    chk("midrst_no_rsp", rsp_count - r0, 0);
    chk("midrst_cmd_ready_up", o_cmd_ready, 1);
    issue(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00);
    wait_idle(100);
    chk("midrst_read_count", rsp_count - r0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_master_q.md
AXI_LITE_MASTER_Q -- requirements
Module: axi_lite_master_q

Interface
REQ-001 Parameter ADDR_W, default 32, AXI address width in bits.
REQ-002 Parameter DATA_W, default 32, AXI data width in bits; legal values are 32 and 64.
REQ-003 Parameter DEPTH, default 4, command FIFO entries; must be a power of 2 and at least 2.
REQ-004 aclk  in  1  clock; all logic is rising-edge.
REQ-005 areset_n  in  1  asynchronous active-low reset.
REQ-006 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-007 cmd_write  in  1  1=write, 0=read.
REQ-008 cmd_addr  in  ADDR_W  target address.
REQ-009 cmd_wdata, cmd_wstrb  in  DATA_W, DATA_W/8  write data and byte strobes; ignored for reads.
REQ-010 rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-011 rsp_write, rsp_rdata, rsp_resp  out  1, DATA_W, 2  response kind, read data (0 for writes), BRESP/RRESP.
REQ-012 awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready  AXI4-Lite write channels, master side.
REQ-013 araddr/arvalid/arready, rdata/rresp/rvalid/rready  AXI4-Lite read channels, master side.
REQ-014 busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE.
REQ-015 err_cnt  out  8  count of responses with a non-OKAY resp; saturates at 255.

Function
REQ-016 Command FIFO
- cmd_ready = !full.
- An entry is pushed on cmd_valid && cmd_ready.
- Push while full is impossible by construction.
- Push and pop in the same cycle are both honoured; the count is unchanged.
REQ-017 FSM states: IDLE, WR, WR_B, RD_A, RD_R, RSP. Exactly one AXI transaction is outstanding at a time.
REQ-018 IDLE, FIFO non-empty: pop the head. Next cycle enters WR (write) or RD_A (read) with the AXI address/data registers loaded.
REQ-019 WR
- awvalid and wvalid assert together.
- Each valid deasserts individually after its own ready handshake.
- AW and W may complete in either order or in the same cycle.
- Move to WR_B once both have completed.
REQ-020 WR_B: bready=1. On bvalid, capture bresp and go to RSP.
REQ-021 RD_A: arvalid=1 until arready, then go to RD_R.
REQ-022 RD_R: rready=1. On rvalid, capture rdata and rresp and go to RSP.
REQ-023 RSP
- rsp_valid=1; rsp_* held stable until rsp_ready.
- On handshake, return to IDLE.
- Back-to-back commands therefore take at least one IDLE cycle between transactions.
REQ-024 While valid and not yet accepted, the AXI payload (addr/data/strb) is held stable; valid is never withdrawn before ready.
REQ-025 err_cnt increments by 1 on the RSP handshake when rsp_resp != 2'b00, unless already 255.
REQ-026 Minimum latency from cmd accept to rsp_valid, with zero-wait slave: 4 cycles for a read, 4 cycles for a write.

Reset
REQ-027 areset_n low asynchronously clears the following, regardless of the state at assertion:
- FIFO pointers and count (to empty).
- FSM (to IDLE).
- err_cnt (to 0).
- All valid/ready outputs to 0, except cmd_ready, which is 0 during reset.
- busy to 0.
- All data outputs to 0.
REQ-028 Outputs after reset release
- cmd_ready rises the first clock after areset_n deasserts.
- An in-flight transaction at reset is abandoned, with no response issued.

Verification
REQ-029 Single write: cmd addr=0x10, data=0xDEADBEEF, strb=0xF, zero-wait slave -> one AW/W pair with these values; rsp_write=1, rsp_resp=0; err_cnt=0.
REQ-030 Read after write: read 0x10, slave returns 0xDEADBEEF -> rsp_rdata=0xDEADBEEF, rsp_write=0.
REQ-031 FIFO full: hold rsp_ready=0 and push DEPTH+1 commands -> cmd_ready=0 after DEPTH+1 accepted (DEPTH queued, 1 in flight); responses drain in order once rsp_ready=1.
REQ-032 AW/W skew: wready 3 cycles before awready, then the reverse order -> payload stable throughout; exactly one B accepted per write.
REQ-033 Error path: slave returns SLVERR on 300 consecutive reads -> rsp_resp=2 each time; err_cnt saturates at 255.
REQ-034 Reset mid-write (in WR_B): assert areset_n=0 -> all valids 0 immediately, busy=0; after release, a new read completes normally.
